// File: rtl/cache_defs_pkg.sv
// Shared definitions for the cache miss fill engine: state encodings, word size and
// block-offset helpers.
package cache_defs_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StDone = 2'd2
  } fill_state_e;

  localparam int unsigned WordBytes = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Clears the byte-in-word and word-in-block bits of an address.
  function automatic logic [63:0] block_mask(input int unsigned words);
    return ~((64'd1 << (clog2(words) + clog2(WordBytes))) - 64'd1);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Index counter that wraps modulo 2**Width, counting how many steps have been taken since
// the last load; saturates once a full lap is done.
module wrap_counter #(
  parameter int unsigned Width = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  input  logic             en_i,
  output logic [Width-1:0] idx_o,
  output logic             last_o,
  output logic             done_o
);

  logic [Width-1:0] idx_q, idx_d;
  logic [Width:0]   cnt_q, cnt_d;

  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (load_i) begin
      idx_d = load_val_i;
      cnt_d = '0;
    end else if (en_i && !done_o) begin
      idx_d = idx_q + {{(Width-1){1'b0}}, 1'b1};
      cnt_d = cnt_q + {{Width{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

  assign idx_o  = idx_q;
  assign done_o = cnt_q[Width];
  assign last_o = (cnt_q == {1'b0, {Width{1'b1}}});

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: fetches one block from pipelined memory, writes each word as it
// arrives, then writes the tag. Define CRIT_WORD_FIRST_EN to fetch the missing word first.
module cache_fill_fsm
  import cache_defs_pkg::*;
#(
  parameter int unsigned DataW = 16,
  parameter int unsigned AddrW = 16,
  parameter int unsigned Words = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     miss_detected_i,
  input  logic [AddrW-1:0]         miss_addr_i,
  input  logic                     mem_data_valid_i,
  input  logic [DataW-1:0]         mem_data_i,
  output logic                     fsm_busy_o,
  output logic                     mem_en_o,
  output logic [AddrW-1:0]         mem_addr_o,
  output logic                     write_data_array_o,
  output logic [clog2(Words)-1:0]  fill_word_o,
  output logic [DataW-1:0]         fill_data_o,
  output logic                     write_tag_array_o
);

  localparam int unsigned IdxW       = clog2(Words);
  localparam int unsigned ByteOffW   = clog2(WordBytes);
  localparam int unsigned BlockOffW  = IdxW + ByteOffW;
  localparam logic [63:0] BlockMask64 = block_mask(Words);
  localparam logic [AddrW-1:0] BlockMask = BlockMask64[AddrW-1:0];

  fill_state_e      state_q, state_d;
  logic [AddrW-1:0] base_q, base_d;
  logic [IdxW-1:0]  start_idx;
  logic [IdxW-1:0]  iss_idx, rcv_idx, addr_idx;
  logic             iss_load, iss_en, iss_done;
  logic             rcv_en, rcv_last, rcv_done;
  logic             unused_iss_last;
  logic             unused_addr_lsbs;

`ifdef CRIT_WORD_FIRST_EN
  assign start_idx = miss_addr_i[ByteOffW +: IdxW];
`else
  assign start_idx = '0;
`endif

  // Offset bits only feed the start index (if at all); the base keeps the block part.
  assign unused_addr_lsbs = ^miss_addr_i[BlockOffW-1:0];

  wrap_counter #(
    .Width (IdxW)
  ) u_issue_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (iss_load),
    .load_val_i (start_idx),
    .en_i       (iss_en),
    .idx_o      (iss_idx),
    .last_o     (unused_iss_last),
    .done_o     (iss_done)
  );

  wrap_counter #(
    .Width (IdxW)
  ) u_recv_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (iss_load),
    .load_val_i (start_idx),
    .en_i       (rcv_en),
    .idx_o      (rcv_idx),
    .last_o     (rcv_last),
    .done_o     (rcv_done)
  );

  // After the last issue the index has wrapped back to start; step back one to hold.
  assign addr_idx = iss_done ? (iss_idx - IdxW'(1)) : iss_idx;

  always_comb begin
    state_d            = state_q;
    base_d             = base_q;
    iss_load           = 1'b0;
    iss_en             = 1'b0;
    rcv_en             = 1'b0;
    fsm_busy_o         = 1'b0;
    mem_en_o           = 1'b0;
    mem_addr_o         = '0;
    write_data_array_o = 1'b0;
    fill_word_o        = '0;
    write_tag_array_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (miss_detected_i) begin
          state_d  = StFill;
          base_d   = miss_addr_i & BlockMask;
          iss_load = 1'b1;
        end
      end
      StFill: begin
        fsm_busy_o = 1'b1;
        mem_en_o   = !iss_done;
        iss_en     = !iss_done;
        mem_addr_o = base_q | (AddrW'(addr_idx) << ByteOffW);
        if (mem_data_valid_i && !rcv_done) begin
          write_data_array_o = 1'b1;
          fill_word_o        = rcv_idx;
          rcv_en             = 1'b1;
          if (rcv_last) state_d = StDone;
        end
      end
      StDone: begin
        fsm_busy_o        = 1'b1;
        write_tag_array_o = 1'b1;
        mem_addr_o        = base_q | (AddrW'(addr_idx) << ByteOffW);
        state_d           = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  assign fill_data_o = mem_data_i;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm: per-cycle vector table for the nominal fill, plus
// hand-written sequences for bubbles, ignored events and mid-fill reset.
module tb_cache_fill_fsm;

`ifdef CRIT_WORD_FIRST_EN
  localparam bit Crit = 1'b1;
`else
  localparam bit Crit = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        miss;
  logic [15:0] miss_addr;
  logic        valid;
  logic [15:0] data;
  logic        busy;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic        wr;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        tag;

  int n_checks = 0;
  int n_fail   = 0;

  cache_fill_fsm #(
    .DataW (16),
    .AddrW (16),
    .Words (8)
  ) dut (
    .clk_i              (clk),
    .rst_ni             (rst_n),
    .miss_detected_i    (miss),
    .miss_addr_i        (miss_addr),
    .mem_data_valid_i   (valid),
    .mem_data_i         (data),
    .fsm_busy_o         (busy),
    .mem_en_o           (mem_en),
    .mem_addr_o         (mem_addr),
    .write_data_array_o (wr),
    .fill_word_o        (fill_word),
    .fill_data_o        (fill_data),
    .write_tag_array_o  (tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: records issued addresses, responses are popped in issue order.
  typedef struct packed {
    logic [15:0] a;
    int          t;
  } pend_t;

  pend_t pend[$];
  int    cyc = 0;
  logic  resp_pop = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      pend.delete();
    end else begin
      if (resp_pop && pend.size() != 0) pend.pop_front();
      if (mem_en) pend.push_back('{a: mem_addr, t: cyc});
    end
  end

  task automatic drive_resp(input bit allow, input int lat);
    if (allow && pend.size() != 0 && cyc >= pend[0].t + lat) begin
      valid    = 1'b1;
      data     = pend[0].a ^ 16'hA5A5;
      resp_pop = 1'b1;
    end else begin
      valid    = 1'b0;
      resp_pop = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int start_of(input logic [15:0] a);
    return Crit ? int'(a[3:1]) : 0;
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    miss     = 1'b0;
    valid    = 1'b0;
    resp_pop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        miss;
    logic        valid;
    logic [15:0] data;
    logic        busy;
    logic        en;
    logic        chk_addr;
    int          ik;
    logic        wr;
    int          rk;
    logic        tag;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int st, nwr, last_wr, nen, r;
    bit seen_tag;

    // Nominal fill, L=4, miss at cycle 0.
    for (int c = 0; c < 15; c++) begin
      tbl[c].miss     = (c == 0);
      tbl[c].valid    = (c >= 5 && c <= 12);
      tbl[c].data     = 16'hC000 + 16'(c);
      tbl[c].busy     = (c >= 1 && c <= 13);
      tbl[c].en       = (c >= 1 && c <= 8);
      tbl[c].chk_addr = (c >= 1 && c <= 12);
      tbl[c].ik       = (c >= 1 && c <= 8) ? c - 1 : 7;
      tbl[c].wr       = (c >= 5 && c <= 12);
      tbl[c].rk       = c - 5;
      tbl[c].tag      = (c == 13);
    end

    miss_addr = 16'h1234;
    data      = 16'h5A5A;
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_mem_en", 32'(mem_en), 0);
    check("reset_mem_addr", 32'(mem_addr), 0);
    check("reset_wr", 32'(wr), 0);
    check("reset_fill_word", 32'(fill_word), 0);
    check("reset_tag", 32'(tag), 0);
    check("reset_fill_data", 32'(fill_data), 32'h5A5A);
    @(posedge clk);
    #1 rst_n = 1'b1;

    st = start_of(16'h1234);
    for (int c = 0; c < 15; c++) begin
      miss  = tbl[c].miss;
      valid = tbl[c].valid;
      data  = tbl[c].data;
      @(negedge clk);
      check($sformatf("tbl%0d_busy", c), 32'(busy), 32'(tbl[c].busy));
      check($sformatf("tbl%0d_mem_en", c), 32'(mem_en), 32'(tbl[c].en));
      check($sformatf("tbl%0d_wr", c), 32'(wr), 32'(tbl[c].wr));
      check($sformatf("tbl%0d_tag", c), 32'(tag), 32'(tbl[c].tag));
      check($sformatf("tbl%0d_fill_data", c), 32'(fill_data), 32'(tbl[c].data));
      if (tbl[c].chk_addr)
        check($sformatf("tbl%0d_mem_addr", c), 32'(mem_addr),
              32'h1230 + 32'(2 * ((tbl[c].ik + st) % 8)));
      if (tbl[c].wr)
        check($sformatf("tbl%0d_fill_word", c), 32'(fill_word), 32'((tbl[c].rk + st) % 8));
      @(posedge clk);
      #1;
    end

    // Valid bubbles: 8 responses spread over ~20 cycles.
    do_reset();
    begin
      logic [19:0] pat;
      pat       = 20'b0100_1010_0010_0100_1011;
      miss_addr = 16'h0A56;
      st        = start_of(16'h0A56);
      nwr       = 0;
      last_wr   = -10;
      seen_tag  = 1'b0;
      r         = 0;
      while (!seen_tag && r < 60) begin
        miss = (r == 0);
        drive_resp((r >= 1 && r <= 20) ? pat[r-1] : 1'b1, 2);
        @(negedge clk);
        if (wr) begin
          check("bub_fill_word", 32'(fill_word), 32'((st + nwr) % 8));
          check("bub_word_matches_addr", 32'(fill_word), 32'(((data ^ 16'hA5A5) >> 1) & 7));
          check("bub_fill_data", 32'(fill_data), 32'(data));
          nwr++;
          last_wr = r;
        end
        if (tag) begin
          seen_tag = 1'b1;
          check("bub_tag_after_last_write", 32'(r), 32'(last_wr + 1));
        end
        @(posedge clk);
        #1;
        r++;
      end
      check("bub_tag_seen", 32'(seen_tag), 1);
      check("bub_write_count", 32'(nwr), 8);
    end

    // Spurious valid in IDLE, miss held through the fill, 9th response in DONE.
    do_reset();
    miss_addr = 16'h3318;
    st        = start_of(16'h3318);
    for (int i = 0; i < 2; i++) begin
      valid = 1'b1;
      data  = 16'hBEEF;
      @(negedge clk);
      check("idle_spurious_wr", 32'(wr), 0);
      check("idle_spurious_busy", 32'(busy), 0);
      @(posedge clk);
      #1;
    end
    nwr      = 0;
    nen      = 0;
    seen_tag = 1'b0;
    r        = 0;
    miss     = 1'b1;
    while (!seen_tag && r < 40) begin
      if (nwr == 8) begin
        valid    = 1'b1;
        data     = 16'hDEAD;
        resp_pop = 1'b0;
      end else begin
        drive_resp(1'b1, 4);
      end
      @(negedge clk);
      if (r >= 1) check("held_busy", 32'(busy), 1);
      if (mem_en) nen++;
      if (wr) nwr++;
      if (tag) begin
        seen_tag = 1'b1;
        check("extra_resp_no_write", 32'(wr), 0);
      end
      @(posedge clk);
      #1;
      r++;
    end
    check("held_tag_seen", 32'(seen_tag), 1);
    check("held_issue_count", 32'(nen), 8);
    check("held_write_count", 32'(nwr), 8);
    valid = 1'b0;
    @(negedge clk);
    check("back_idle_busy", 32'(busy), 0);
    check("back_idle_mem_en", 32'(mem_en), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("refill_busy", 32'(busy), 1);
    check("refill_mem_en", 32'(mem_en), 1);
    check("refill_addr", 32'(mem_addr), 32'h3310 + 32'(2 * st));
    @(posedge clk);
    #1 miss = 1'b0;

    // Reset asserted in cycle 6 of a fill, then a clean fill to 0x0040.
    do_reset();
    miss_addr = 16'h1234;
    for (int c = 0; c < 6; c++) begin
      miss = (c == 0);
      drive_resp(1'b1, 4);
      @(negedge clk);
      check("abort_no_tag", 32'(tag), 0);
      @(posedge clk);
      #1;
    end
    drive_resp(1'b1, 4);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_mem_en", 32'(mem_en), 0);
    check("abort_mem_addr", 32'(mem_addr), 0);
    check("abort_wr", 32'(wr), 0);
    check("abort_fill_word", 32'(fill_word), 0);
    check("abort_tag", 32'(tag), 0);
    valid    = 1'b0;
    resp_pop = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    miss_addr = 16'h0040;
    seen_tag  = 1'b0;
    r         = 0;
    while (!seen_tag && r < 40) begin
      miss = (r == 0);
      drive_resp(1'b1, 4);
      @(negedge clk);
      if (r >= 1 && r <= 8) begin
        check("clean_mem_en", 32'(mem_en), 1);
        check("clean_mem_addr", 32'(mem_addr), 32'h0040 + 32'(2 * (r - 1)));
      end
      if (tag) seen_tag = 1'b1;
      @(posedge clk);
      #1;
      r++;
    end
    check("clean_tag_seen", 32'(seen_tag), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
